mult_pipe_sv: RTL and testbench
===============================

// Module: mult_pipe_sv
// PURPOSE
//   Parametrised multi-cycle integer multiplier: WIDTH x WIDTH -> 2*WIDTH product.
//   Supports both signed (MULT) and unsigned (MULTU) operation.
//   Operands are latched on start and pass through a registered binary adder tree.
//   Sits in the CPU execute stage and feeds HI/LO. The controller stalls on done=0.
// PARAMETERS
//   WIDTH   32   operand width; must be a power of 2, >=4; other values -> elaboration error
//   LOG2W   $clog2(WIDTH)   derived, not overridable; number of adder-tree levels
//   LATENCY LOG2W+2         derived; cycles from start acceptance to done=1 (7 at WIDTH=32)
// PORTS
//   clk        in   1        clock; all state updates on FALLING edge (CPU datapath convention)
//   reset      in   1        asynchronous, active-low reset
//   a          in   WIDTH    multiplicand; sampled only on the accepting edge
//   b          in   WIDTH    multiplier; sampled only on the accepting edge
//   signed_op  in   1        1 = two's-complement operands, 0 = unsigned; sampled with a/b
//   start      in   1        request; accepted only when done=1
//   z          out  2*WIDTH  product; z[2W-1:W] = HI, z[W-1:0] = LO
//   done       out  1        1 = idle, z valid; 0 = operation in flight
// BEHAVIOUR
//   Reset (reset=0, async): z=0, done=1, all pipeline registers cleared, cycle counter=0.
//     Reset mid-operation aborts the operation; no result is produced.
//   Accept: at falling edge E, if done==1 && start==1:
//     - latch |a|, |b| (abs only when signed_op=1) and neg = signed_op & (a[W-1]^b[W-1]);
//     - done<=0.
//   Stage 0 (edge E): WIDTH partial products pp[i] = b_mag[i] ? (a_mag<<i) : 0, each 2*WIDTH wide.
//   Stages 1..LOG2W: each level adds adjacent pairs, registered; WIDTH/2^k sums at level k.
//   Final stage (edge E+LATENCY):
//     - z <= neg ? -sum : sum;
//     - done <= 1.
//   z is stable from E+LATENCY until the next completion. It is not cleared on accept.
//   Magnitude rule: |-2^(W-1)| = 2^(W-1) fits unsigned in WIDTH bits, so there is no special case.
//     Products are exact; no overflow is possible.
//   start while done==0 is ignored. Operands are not re-sampled; a/b/signed_op may change freely.
//   start at the completion edge E+LATENCY is ignored (done is still 0 at that edge).
//     Earliest re-accept is E+LATENCY+1, so throughput is 1 op per LATENCY+1 cycles.
//   An internal down-counter (LOG2W+2 bits) tracks in-flight stages.
//     Pipeline registers update only while busy, which holds power when idle.
//   States:
//     - IDLE (done=1) -> BUSY on accept;
//     - BUSY -> IDLE when counter expires;
//     - any -> IDLE on reset.
//   Unknown inputs while idle and start=0 have no effect on z or done.
// TESTING
//   1. W=32 unsigned, a=b=0xFFFFFFFF, start 1 cycle -> done=0 for 7 edges, then z=0xFFFFFFFE00000001, done=1.
//   2. W=32 signed: -3*5 -> z=0xFFFFFFFFFFFFFFF1; -1*-1 -> z=1; 0x80000000*0x80000000 -> z=0x4000000000000000.
//   3. Accept 7*6 unsigned, hold start=1 and change a/b mid-op -> z=42 at E+7.
//      Second op accepted at E+8, not E+7.
//   4. Assert reset low at E+3 of an op -> z=0, done=1 immediately (async).
//      No completion follows; next start behaves normally.
//   5. W=8 instance, unsigned 0xFF*0xFF -> z=0xFE01 after 5 edges.
//      Signed 0x80*0x7F -> z=0xC080.
//   6. Random 10k signed/unsigned ops vs. reference model, with start gaps 0-3 cycles -> all match, done timing exact.

Source files
------------

// File: rtl/mult_pipe_sv.sv
// -----------------------------------------------------------------------------
// mult_pipe_sv
//   Multi-cycle WIDTH x WIDTH -> 2*WIDTH integer multiplier for the execute
//   stage (feeds HI/LO). Signed (MULT) and unsigned (MULTU) operation.
//   Operands are reduced to magnitudes on acceptance. WIDTH shifted partial
//   products then pass through a registered binary adder tree, and the sign is
//   applied in the final stage. All state changes on the FALLING clock edge.
//
//   Timing: accept at edge E (done=1 && start=1), so done=0 from E and z/done
//   update at E+LATENCY, where LATENCY = $clog2(WIDTH)+2.
//     E               : latch |a|, |b| and the result sign
//     E+1             : partial products registered (tree leaves)
//     E+2..E+1+LOG2W  : one adder-tree level settles per edge
//     E+LATENCY       : z <= signed result, done <= 1
//
// Ports
//   clk        in   1        clock (falling edge active)
//   reset      in   1        asynchronous, active-low reset
//   a, b       in   WIDTH    operands, sampled only on the accepting edge
//   signed_op  in   1        1 = two's complement, 0 = unsigned
//   start      in   1        request, accepted only while done=1
//   z          out  2*WIDTH  product; z[2W-1:W] = HI, z[W-1:0] = LO
//   done       out  1        1 = idle and z valid, 0 = busy
// -----------------------------------------------------------------------------
module mult_pipe_sv #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               signed_op,
    input  logic               start,
    output logic [2*WIDTH-1:0] z,
    output logic               done
);

    localparam int LOG2W   = $clog2(WIDTH);
    localparam int LATENCY = LOG2W + 2;
    localparam int CW      = LOG2W + 2;
    // The tree is stored heap-style: node i has children 2i+1 and 2i+2.
    // Leaves (the partial products) occupy WIDTH-1 .. 2*WIDTH-2, and the root is 0.
    localparam int NODES   = 2 * WIDTH - 1;

    if (WIDTH < 4 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $error("mult_pipe_sv: WIDTH must be a power of 2 and >= 4");
    end

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state, state_next;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic               neg;
    logic               accept, expire;
    logic [2*WIDTH-1:0] tree [NODES];

    // The magnitude of -2^(W-1) is 2^(W-1), which still fits as an unsigned
    // W-bit value, so plain negation needs no special case.
    assign a_abs  = (signed_op && a[WIDTH-1]) ? -a : a;
    assign b_abs  = (signed_op && b[WIDTH-1]) ? -b : b;

    assign accept = (state == IDLE) && start;
    assign expire = (state == BUSY) && (cnt == '0);

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        done       = (state == IDLE);
        case (state)
            IDLE:    if (accept) state_next = BUSY;
            BUSY:    if (expire) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples values from before the edge and ordering between blocks does not matter.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Operand capture and in-flight counter. cnt reaches 0 exactly at
    // E+LATENCY-1, so the final stage fires on the next edge.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            a_mag <= '0;
            b_mag <= '0;
            neg   <= 1'b0;
            cnt   <= '0;
        end else if (accept) begin
            a_mag <= a_abs;
            b_mag <= b_abs;
            neg   <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
            cnt   <= CW'(LATENCY - 1);
        end else if (state == BUSY && cnt != '0) begin
            cnt   <= cnt - CW'(1);
        end
    end

    // Partial products and adder tree. The tree only toggles while busy. Stale
    // values from a previous operation flush out because the root is read
    // only after LOG2W+1 busy edges.
    // NOTE: the tree is cleared on reset as well. Nothing requires that for
    // correctness, but it keeps a mid-operation abort fully deterministic.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NODES; i++) tree[i] <= '0;
        end else if (state == BUSY) begin
            for (int i = 0; i < WIDTH; i++)
                tree[WIDTH-1+i] <= b_mag[i] ? ({{WIDTH{1'b0}}, a_mag} << i) : '0;
            for (int i = 0; i < WIDTH - 1; i++)
                tree[i] <= tree[2*i+1] + tree[2*i+2];
        end
    end

    // The result register holds its value until the next completion and is
    // not cleared when a new operation is accepted.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset)      z <= '0;
        else if (expire) z <= neg ? -tree[0] : tree[0];
    end

endmodule

// File: tb/tb_mult_pipe_sv.sv
// -----------------------------------------------------------------------------
// tb_mult_pipe_sv
//   Directed bench for mult_pipe_sv. It uses a WIDTH=32 instance and a WIDTH=8
//   instance. The DUT acts on falling edges. The bench drives inputs and
//   samples outputs on rising edges, half a cycle away from the DUT's edge.
// -----------------------------------------------------------------------------
module tb_mult_pipe_sv;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] a32, b32;
    logic        s32, start32;
    logic [63:0] z32;
    logic        done32;
    logic [7:0]  a8, b8;
    logic        s8, start8;
    logic [15:0] z8;
    logic        done8;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mult_pipe_sv #(.WIDTH(32)) u_dut32 (
        .clk(clk), .reset(reset), .a(a32), .b(b32), .signed_op(s32),
        .start(start32), .z(z32), .done(done32)
    );

    mult_pipe_sv #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(reset), .a(a8), .b(b8), .signed_op(s8),
        .start(start8), .z(z8), .done(done8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One operation on the 32-bit instance. Start is pulsed for one cycle, then
    // the operands are scrambled so that re-sampling would be visible. The
    // task counts the rising-edge samples that show done=0, which equals LATENCY.
    task automatic run32(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [63:0] exp);
        int busy = 0;
        @(posedge clk);
        a32 = a; b32 = b; s32 = s; start32 = 1'b1;
        @(posedge clk);
        start32 = 1'b0; a32 = ~a; b32 = ~b; s32 = ~s;
        for (int i = 0; i < 20; i++) begin
            if (done32) break;
            busy++;
            @(posedge clk);
        end
        check({tag, " latency"}, 64'(busy), 64'd7);
        check({tag, " z"}, z32, exp);
    endtask

    task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic s, input logic [15:0] exp);
        int busy = 0;
        @(posedge clk);
        a8 = a; b8 = b; s8 = s; start8 = 1'b1;
        @(posedge clk);
        start8 = 1'b0; a8 = ~a; b8 = ~b; s8 = ~s;
        for (int i = 0; i < 20; i++) begin
            if (done8) break;
            busy++;
            @(posedge clk);
        end
        check({tag, " latency"}, 64'(busy), 64'd5);
        check({tag, " z"}, 64'(z8), 64'(exp));
    endtask

    initial begin
        reset = 1'b0;
        a32 = '0; b32 = '0; s32 = 1'b0; start32 = 1'b0;
        a8 = '0; b8 = '0; s8 = 1'b0; start8 = 1'b0;
        #23;
        check("reset z32", z32, 64'd0);
        check("reset done32", 64'(done32), 64'd1);
        check("reset z8", 64'(z8), 64'd0);
        check("reset done8", 64'(done8), 64'd1);
        @(posedge clk);
        reset = 1'b1;

        // Unknown operands while idle with start=0 must not disturb anything.
        a32 = 'x; b32 = 'x; s32 = 'x;
        repeat (3) @(posedge clk);
        check("idle x z32", z32, 64'd0);
        check("idle x done32", 64'(done32), 64'd1);

        // Unsigned and signed vectors, including the extreme magnitudes.
        run32("u max*max",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
        run32("s -3*5",      32'hFFFF_FFFD, 32'd5,         1'b1, 64'hFFFF_FFFF_FFFF_FFF1);
        run32("u fffffffd*5",32'hFFFF_FFFD, 32'd5,         1'b0, 64'h0000_0004_FFFF_FFF1);
        run32("s -1*-1",     32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'd1);
        run32("s min*min",   32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
        run32("s max*min",   32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 64'hC000_0000_8000_0000);
        run32("u 2^31*2",    32'h8000_0000, 32'd2,         1'b0, 64'h0000_0001_0000_0000);
        run32("s 0*-5",      32'd0,         32'hFFFF_FFFB, 1'b1, 64'd0);

        // Start held high through an operation. Operands change mid-operation,
        // the completion edge must not accept, and re-accept happens one edge later.
        begin
            int busy = 0;
            @(posedge clk);
            a32 = 32'd7; b32 = 32'd6; s32 = 1'b0; start32 = 1'b1;
            @(posedge clk);
            a32 = 32'd3; b32 = 32'd4;
            for (int i = 0; i < 20; i++) begin
                if (done32) break;
                busy++;
                @(posedge clk);
            end
            check("held start latency", 64'(busy), 64'd7);
            check("held start z", z32, 64'd42);
            check("held start done after E+7", 64'(done32), 64'd1);
            @(posedge clk);
            start32 = 1'b0;
            check("re-accept at E+8", 64'(done32), 64'd0);
            check("z kept on accept", z32, 64'd42);
            busy = 0;
            for (int i = 0; i < 20; i++) begin
                if (done32) break;
                busy++;
                @(posedge clk);
            end
            check("second op latency", 64'(busy), 64'd7);
            check("second op z", z32, 64'd12);
        end

        // Asynchronous reset during an operation aborts it, and no completion follows.
        @(posedge clk);
        a32 = 32'd9; b32 = 32'd9; s32 = 1'b0; start32 = 1'b1;
        @(posedge clk);
        start32 = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("abort z", z32, 64'd0);
        check("abort done", 64'(done32), 64'd1);
        @(posedge clk);
        reset = 1'b1;
        repeat (10) @(posedge clk);
        check("no completion z", z32, 64'd0);
        check("no completion done", 64'(done32), 64'd1);
        run32("after abort 9*9", 32'd9, 32'd9, 1'b0, 64'd81);

        // 8-bit instance.
        run8("w8 u ff*ff",  8'hFF, 8'hFF, 1'b0, 16'hFE01);
        run8("w8 s 80*7f",  8'h80, 8'h7F, 1'b1, 16'hC080);
        run8("w8 s -1*-1",  8'hFF, 8'hFF, 1'b1, 16'h0001);
        run8("w8 s 80*80",  8'h80, 8'h80, 1'b1, 16'h4000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
